serial_sub: RTL and testbench

- Bit-serial N-bit subtractor: computes a − b one bit per clock, LSB first, using a half-subtractor cell plus a registered borrow flip-flop.
- Inverse counterpart of the combinational half-add/carry macros; used where a narrow area budget favours a multi-cycle compare/subtract, e.g. blitter/DSP address-delta and compare paths.
- start/busy/done handshake; result and flags held stable until the next completion.

---
 rtl/serial_sub.sv | 111 +++++++++++
 tb/tb_serial_sub.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first) with a start/busy/done handshake.
// Optional macro SERIAL_SUB_SAT_EN: saturate diff at zero when the final borrow is set.
module serial_sub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             MasterClock,
  input  logic             resetl,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, sd_q;
  logic             bff_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q, zero_q;

  // Half-subtractor cell plus borrow-in from the borrow flip-flop.
  logic             x, y, bi, d, bo;
  logic [WIDTH-1:0] sd_d;
  logic [WIDTH-1:0] res_diff;
  logic             res_zero;

  always_comb begin
    x    = sa_q[0];
    y    = sb_q[0];
    bi   = bff_q;
    d    = x ^ y ^ bi;
    bo   = (~x & y) | (~(x ^ y) & bi);
    sd_d = {d, sd_q[WIDTH-1:1]};
`ifdef SERIAL_SUB_SAT_EN
    res_diff = bo ? '0 : sd_d;
`else
    res_diff = sd_d;
`endif
    res_zero = (res_diff == '0);
  end

  always_ff @(posedge MasterClock or negedge resetl) begin
    if (!resetl) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      sd_q     <= '0;
      bff_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= StRun;
            sa_q    <= a;
            sb_q    <= b;
            bff_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StRun: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          sd_q  <= sd_d;
          bff_q <= bo;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_q  <= StDone;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= res_diff;
            borrow_q <= bo;
            zero_q   <= res_zero;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed table, corner sequences and random ops vs model.
module tb_serial_sub;

  localparam int unsigned W = 16;

  logic         clk;
  logic         resetl;
  logic         start;
  logic [W-1:0] a_i, b_i;
  logic         busy, done, borrow, zero;
  logic [W-1:0] diff;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] prev_diff;

  serial_sub #(.WIDTH(W)) dut (
    .MasterClock(clk),
    .resetl     (resetl),
    .start      (start),
    .a          (a_i),
    .b          (b_i),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow     (borrow),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                output logic [W-1:0] md, output logic mbo, output logic mz);
    int unsigned full;
    full = {16'h0, ma} - {16'h0, mb};
    md   = full[W-1:0];
    mbo  = (ma < mb);
`ifdef SERIAL_SUB_SAT_EN
    if (mbo) md = '0;
`endif
    mz = (md == '0);
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or on timeout).
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int inject,
                        output logic [W-1:0] ed, output logic eb, output logic ez);
    int   lat;
    int   busy_cnt;
    logic held_ok;
    a_i   = ta;
    b_i   = tb;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    held_ok  = 1'b1;
    while (!done && lat < 4 * W) begin
      if (busy) busy_cnt++;
      if (diff !== prev_diff) held_ok = 1'b0;
      if (lat == inject) begin
        start = 1'b1;
        a_i   = '0;
        b_i   = '0;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    model(ta, tb, ed, eb, ez);
    check("latency", lat, W);
    check("busy_cycles", busy_cnt, W);
    check("held_during_run", {31'h0, held_ok}, 1);
    check("busy_at_done", {31'h0, busy}, 0);
    check("diff", {16'h0, diff}, {16'h0, ed});
    check("borrow", {31'h0, borrow}, {31'h0, eb});
    check("zero", {31'h0, zero}, {31'h0, ez});
    prev_diff = ed;
  endtask

  initial begin
    logic [W-1:0] ed;
    logic         eb, ez;
    int           seen;

    vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0};
`ifdef SERIAL_SUB_SAT_EN
    vecs[1] = '{16'h0000, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b1};
`else
    vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0};
    vecs[4] = '{16'h0001, 16'hFFFF, 16'h0002, 1'b1, 1'b0};
`endif
    vecs[2] = '{16'hBEEF, 16'hBEEF, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0};

    resetl    = 1'b0;
    start     = 1'b0;
    a_i       = '0;
    b_i       = '0;
    prev_diff = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_done", {31'h0, done}, 0);
    check("rst_diff", {16'h0, diff}, 0);
    check("rst_borrow", {31'h0, borrow}, 0);
    check("rst_zero", {31'h0, zero}, 1);
    resetl = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("idle_no_done", seen, 0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, -1, ed, eb, ez);
      check($sformatf("tbl%0d_diff", i), {16'h0, diff}, {16'h0, vecs[i].diff});
      check($sformatf("tbl%0d_borrow", i), {31'h0, borrow}, {31'h0, vecs[i].borrow});
      check($sformatf("tbl%0d_zero", i), {31'h0, zero}, {31'h0, vecs[i].zero});
      @(negedge clk);
      check("done_single", {31'h0, done}, 0);
    end

    // Prime a nonzero result, then start mid-RUN must be ignored.
    run_op(16'h1234, 16'h0234, -1, ed, eb, ez);
    @(negedge clk);
    run_op(16'hBEEF, 16'hBEEF, 5, ed, eb, ez);
    check("ignored_start_diff", {16'h0, diff}, 0);
    check("ignored_start_zero", {31'h0, zero}, 1);
    @(negedge clk);
    check("ignored_no_rerun", {31'h0, busy}, 0);

    // Back-to-back: launch the second op in the DONE cycle.
    run_op(16'h1111, 16'h0011, -1, ed, eb, ez);
    check("b2b_first", {16'h0, diff}, 32'h1100);
    run_op(16'h8000, 16'h0001, -1, ed, eb, ez);
    check("b2b_second", {16'h0, diff}, 32'h7FFF);
    @(negedge clk);

    // Reset asserted at cycle 8 of RUN.
    a_i   = 16'hFFFF;
    b_i   = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 resetl = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 0);
    check("midrst_done", {31'h0, done}, 0);
    check("midrst_diff", {16'h0, diff}, 0);
    check("midrst_borrow", {31'h0, borrow}, 0);
    check("midrst_zero", {31'h0, zero}, 1);
    @(negedge clk);
    resetl    = 1'b1;
    prev_diff = '0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || diff != '0) seen++;
    end
    check("midrst_quiet", seen, 0);

    // Random operands against the model.
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) rb = ra;
      run_op(ra, rb, (i % 3 == 0) ? int'($urandom_range(0, W - 2)) : -1, ed, eb, ez);
      if (($urandom & 1) == 0) begin
        @(negedge clk);
        check("rnd_done_single", {31'h0, done}, 0);
        check("rnd_hold", {16'h0, diff}, {16'h0, ed});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
